// File: rtl/spart_pkg.sv
// -----------------------------------------------------------------------------
// spart_pkg -- shared definitions for the SPART transmitter.
//
// Contents:
//   tx_state_t        transmitter FSM state encoding (IDLE/START/DATA/PARITY/STOP)
//   DATA_W_MIN/MAX    legal range of data bits per frame
//   STOP_BITS_MIN/MAX legal range of stop bits per frame
// -----------------------------------------------------------------------------
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_W_MIN    = 5;
    localparam int DATA_W_MAX    = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/spart_tx_fifo.sv
// -----------------------------------------------------------------------------
// spart_tx_fifo -- transmit word FIFO for the SPART transmitter.
//
// Parameters:
//   DATA_W      word width
//   FIFO_DEPTH  number of entries (power of two, so pointers wrap naturally)
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push       write request; accepted when not full, or when full and a pop
//              happens in the same cycle
//   pop        read request from the transmitter; only honoured when not empty
//   din        word to store
//   dout       word at the head of the FIFO
//   full       FIFO holds FIFO_DEPTH words
//   empty      FIFO holds no words
//   count      current occupancy (registered)
//   overflow   one-cycle pulse, the cycle after a push was dropped
// -----------------------------------------------------------------------------
module spart_tx_fifo
    import spart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             din,
    output logic [DATA_W-1:0]             dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              overflow_q;

    logic do_push;
    logic do_pop;

    // Occupancy is registered, so a word pushed into an empty FIFO is not
    // visible as "not empty" until the following cycle.
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            overflow_q <= push && !do_push;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout     = mem[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/spart_tx_param.sv
// -----------------------------------------------------------------------------
// spart_tx_param -- parameterised SPART serial transmitter with transmit FIFO.
//
// Parameters:
//   DATA_W      data bits per frame (5..9)
//   FIFO_DEPTH  transmit FIFO entries (power of two, 2..16)
//   STOP_BITS   stop bits per frame (1 or 2)
//
// Configuration macro:
//   SPART_TX_PARITY_EN  when defined, a parity bit (XOR of data bits XOR
//                       parity_odd) follows the data bits; otherwise DATA goes
//                       straight to STOP and parity_odd is unused.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   tx_enable   baud tick, one-cycle pulse per bit period
//   write       push tx_in into the FIFO this cycle
//   tx_in       data word to transmit
//   parity_odd  1 = odd parity, 0 = even parity
//   txd         registered serial line, idle high
//   tbr         transmit buffer ready (FIFO not full)
//   busy        frame on the line (state != IDLE)
//   fifo_count  FIFO occupancy
//   overflow    one-cycle pulse when a write is dropped
//
// Handshake: write/tbr follow valid/ready semantics -- a word is taken on any
// rising edge where write=1 and tbr=1 (or the FIFO is full but the transmitter
// pops in that same cycle). A write with tbr=0 and no same-cycle pop is dropped
// and reported on overflow the following cycle; the producer should hold off
// while tbr=0.
// -----------------------------------------------------------------------------
module spart_tx_param
    import spart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_enable,
    input  logic                          write,
    input  logic [DATA_W-1:0]             tx_in,
    input  logic                          parity_odd,
    output logic                          txd,
    output logic                          tbr,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int                BW        = $clog2(DATA_W);
    localparam logic [BW-1:0]     LAST_BIT  = BW'(DATA_W - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("spart_tx_param: DATA_W out of range");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("spart_tx_param: STOP_BITS out of range");
    end

    // FIFO interface
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    spart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (write),
        .pop      (fifo_pop),
        .din      (tx_in),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (overflow)
    );

    // Transmitter state
    tx_state_t         state_q,    state_d;
    logic [BW-1:0]     bit_cnt_q,  bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic [DATA_W-1:0] shifter_q,  shifter_d;
    logic              txd_q,      txd_d;

`ifdef SPART_TX_PARITY_EN
    logic              parity_q,   parity_d;
`else
    logic              unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shifter_d  = shifter_q;
        fifo_pop   = 1'b0;
`ifdef SPART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (tx_enable && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (tx_enable) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tx_enable) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        stop_cnt_d = 1'b0;
`ifdef SPART_TX_PARITY_EN
                        state_d    = PARITY;
`else
                        state_d    = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shifter_d = shifter_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tx_enable) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (tx_enable) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        // Chain straight into the next frame when a word waits.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            state_d  = START;
                        end else begin
                            state_d  = IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Every pop loads the head word; parity is fixed at load time.
        if (fifo_pop) begin
            shifter_d = fifo_dout;
`ifdef SPART_TX_PARITY_EN
            parity_d  = (^fifo_dout) ^ parity_odd;
`endif
        end

        // Line level is decided from the next state so txd can be registered
        // without an extra bit of latency.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shifter_d[0];
`ifdef SPART_TX_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shifter_q  <= '0;
            txd_q      <= 1'b1;
`ifdef SPART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shifter_q  <= shifter_d;
            txd_q      <= txd_d;
`ifdef SPART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign txd  = txd_q;
    assign busy = (state_q != IDLE);
    assign tbr  = !fifo_full;

endmodule

// File: tb/tb_spart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_spart_tx_param -- directed self-checking bench for spart_tx_param.
// Instance u_dut_a: DATA_W=8, FIFO_DEPTH=4, STOP_BITS=1.
// Instance u_dut_b: DATA_W=5, FIFO_DEPTH=2, STOP_BITS=2 (shares clk, rst,
// tx_enable and parity_odd; has its own write path and is idle otherwise).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spart_tx_param;

`ifdef SPART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_A = 1 + 8 + PAR_BITS + 1;
    localparam int FRAME_B = 1 + 5 + PAR_BITS + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       tx_enable  = 1'b0;
    logic       parity_odd = 1'b0;
    logic       write      = 1'b0;
    logic [7:0] tx_in      = '0;
    logic       txd, tbr, busy, overflow;
    logic [2:0] fifo_count;

    logic       b_write    = 1'b0;
    logic [4:0] b_tx_in    = '0;
    logic       b_txd, b_tbr, b_busy, b_overflow;
    logic [1:0] b_fifo_count;

    spart_tx_param #(.DATA_W(8), .FIFO_DEPTH(4), .STOP_BITS(1)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .tx_enable  (tx_enable),
        .write      (write),
        .tx_in      (tx_in),
        .parity_odd (parity_odd),
        .txd        (txd),
        .tbr        (tbr),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    spart_tx_param #(.DATA_W(5), .FIFO_DEPTH(2), .STOP_BITS(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .tx_enable  (tx_enable),
        .write      (b_write),
        .tx_in      (b_tx_in),
        .parity_odd (parity_odd),
        .txd        (b_txd),
        .tbr        (b_tbr),
        .busy       (b_busy),
        .fifo_count (b_fifo_count),
        .overflow   (b_overflow)
    );

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected line bits for one frame: start, data LSB first, parity, stop(s).
    task automatic push_frame(input logic [8:0] d, input int w, input int stop, input logic podd);
        logic p;
        p = podd;
        exp_q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (PAR_BITS == 1) exp_q.push_back(p);
        for (int i = 0; i < stop; i++) exp_q.push_back(1'b1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_a(input logic [7:0] d);
        write = 1'b1;
        tx_in = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    // Wait gap cycles, issue one baud tick, then compare the line with the
    // next expected bit (idle high once the queue is drained).
    task automatic tick_check(input bit on_b, input int gap, input string tag);
        logic [0:0] e;
        idle_cycles(gap);
        tx_enable = 1'b1;
        @(negedge clk);
        tx_enable = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
        check(tag, on_b ? b_txd : txd, e);
    endtask

    // ---------------- stimulus ----------------
    logic line_22 [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic data_07 [9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        // Reset state
        rst = 1'b1;
        idle_cycles(3);
        check("rst_txd",        txd, 1);
        check("rst_busy",       busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_tbr",        tbr, 1);
        check("rst_overflow",   overflow, 0);
        check("rst_b_txd",      b_txd, 1);
        rst = 1'b0;
        idle_cycles(2);

        // Single frame 8'h22, tick every 31 cycles
        write_a(8'h22);
        check("f22_count", fifo_count, 1);
        for (int i = 0; i < 9; i++) exp_q.push_back(line_22[i]);
        if (PAR_BITS == 1) exp_q.push_back(1'b0);   // two ones, even parity
        exp_q.push_back(line_22[9]);
        for (int i = 0; i < FRAME_A + 1; i++) begin
            tick_check(0, 30, $sformatf("f22_txd%0d", i));
            if (i == 0) begin
                check("f22_busy", busy, 1);
                check("f22_count_pop", fifo_count, 0);
            end
        end
        check("f22_busy_end", busy, 0);

        // Back-to-back frames
        write_a(8'hA5);
        write_a(8'h3C);
        check("b2b_count2", fifo_count, 2);
        push_frame(9'h0A5, 8, 1, parity_odd);
        push_frame(9'h03C, 8, 1, parity_odd);
        for (int i = 0; i < 2 * FRAME_A + 1; i++) begin
            tick_check(0, 3, $sformatf("b2b_txd%0d", i));
            if (i == 0)       check("b2b_count1", fifo_count, 1);
            if (i == FRAME_A) check("b2b_count0", fifo_count, 0);
        end
        check("b2b_busy_end", busy, 0);

        // Overflow: five writes, no ticks
        for (int k = 0; k < 5; k++) begin
            write_a(8'h11 * 8'(k + 1));
            if (k == 3) begin
                check("ovf_tbr_full", tbr, 0);
                check("ovf_count4",   fifo_count, 4);
                check("ovf_no_pulse", overflow, 0);
            end
            if (k == 4) check("ovf_pulse", overflow, 1);
        end
        idle_cycles(1);
        check("ovf_pulse_end", overflow, 0);
        check("ovf_count_kept", fifo_count, 4);
        push_frame(9'h011, 8, 1, parity_odd);
        push_frame(9'h022, 8, 1, parity_odd);
        push_frame(9'h033, 8, 1, parity_odd);
        push_frame(9'h044, 8, 1, parity_odd);
        for (int i = 0; i < 4 * FRAME_A + 3; i++) begin
            tick_check(0, 2, $sformatf("ovf_txd%0d", i));
        end
        check("ovf_busy_end", busy, 0);
        check("ovf_count_end", fifo_count, 0);
        check("ovf_tbr_end", tbr, 1);

        // Parity sense with 8'h07 (three ones)
        for (int s = 0; s < 2; s++) begin
            parity_odd = 1'(s);
            write_a(8'h07);
            for (int i = 0; i < 9; i++) exp_q.push_back(data_07[i]);
            if (PAR_BITS == 1) exp_q.push_back((s == 0) ? 1'b1 : 1'b0);
            exp_q.push_back(1'b1);
            for (int i = 0; i < FRAME_A + 1; i++) begin
                tick_check(0, 2, $sformatf("par%0d_txd%0d", s, i));
            end
        end
        parity_odd = 1'b0;

        // Reset during DATA bit 3 with a second word queued
        write_a(8'h5A);
        write_a(8'h66);
        push_frame(9'h05A, 8, 1, parity_odd);
        for (int i = 0; i < 5; i++) tick_check(0, 2, $sformatf("mid_txd%0d", i));
        check("mid_busy", busy, 1);
        rst       = 1'b1;
        write     = 1'b1;
        tx_in     = 8'h77;
        tx_enable = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        write     = 1'b0;
        tx_enable = 1'b0;
        exp_q.delete();
        check("mid_rst_txd",   txd, 1);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_tbr",   tbr, 1);
        for (int i = 0; i < 3; i++) begin
            tick_check(0, 2, $sformatf("mid_idle_txd%0d", i));
            check($sformatf("mid_idle_busy%0d", i), busy, 0);
        end

        // DATA_W=5, STOP_BITS=2, word 5'h1F
        b_write = 1'b1;
        b_tx_in = 5'h1F;
        @(negedge clk);
        b_write = 1'b0;
        check("b_count1", b_fifo_count, 1);
        push_frame(9'h01F, 5, 2, parity_odd);
        for (int i = 0; i < FRAME_B + 1; i++) begin
            tick_check(1, 2, $sformatf("b_txd%0d", i));
            if (i == FRAME_B - 1) check("b_busy_stop2", b_busy, 1);
        end
        check("b_busy_end", b_busy, 0);
        check("b_count_end", b_fifo_count, 0);
        check("a_untouched", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spart_tx_param.md
SPART_TX_PARAM -- requirements
Module: spart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port tx_enable  input  1  baud tick; one-cycle pulse per bit period.
REQ-007 SHALL have port write  input  1  push tx_in into FIFO this cycle.
REQ-008 SHALL have port tx_in  input  DATA_W  data word to transmit.
REQ-009 SHALL have port parity_odd  input  1  parity sense: 1 = odd, 0 = even; ignored without SPART_TX_PARITY_EN.
REQ-010 SHALL have port txd  output  1  serial line; idle high.
REQ-011 SHALL have port tbr  output  1  transmit buffer ready; high when FIFO not full.
REQ-012 SHALL have port busy  output  1  high while a frame is on the line (any state other than IDLE).
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL leave IDLE only on a cycle where tx_enable=1 and fifo_count>0: pop head, load shifter, enter START.
REQ-017 SHALL drive txd=0 in START, txd=shifter[0] in DATA, txd=parity bit in PARITY, txd=1 in STOP and IDLE; txd registered.
REQ-018 SHALL advance START->DATA, DATA bit i->i+1, DATA(last)->PARITY or STOP, PARITY->STOP, STOP->next only on tx_enable pulses.
REQ-019 SHALL transmit data LSB first, exactly DATA_W bits, one bit period each.
REQ-020 SHALL hold STOP for STOP_BITS bit periods; on the final STOP tick, with FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap), else IDLE.
REQ-021 SHALL accept write when fifo_count<FIFO_DEPTH, or when full and a pop occurs the same cycle.
REQ-022 SHALL drop a write to a full FIFO with no same-cycle pop, leave contents unchanged, and pulse overflow for one cycle.
REQ-023 SHALL not pop a word written in the same cycle into an empty FIFO; it is eligible from the next cycle.
REQ-024 SHALL update fifo_count and tbr one cycle after the write/pop edge; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL ignore tx_enable pulses in IDLE when the FIFO is empty.

Reset
REQ-026 SHALL on rst=1 at a clock edge force state IDLE, txd=1, busy=0, fifo_count=0, tbr=1, overflow=0, bit counter 0, and FIFO pointers 0.
REQ-027 SHALL abort any frame in progress on reset, returning txd high the cycle after the reset edge, and discard all queued words.
REQ-028 SHALL have rst take priority over write and tx_enable in the same cycle.

Configuration
REQ-029 SHALL, with macro SPART_TX_PARITY_EN defined, insert the PARITY state after DATA, sending XOR of data bits XOR parity_odd.
REQ-030 SHALL, without SPART_TX_PARITY_EN, omit the PARITY state entirely (DATA->STOP) and leave parity_odd unused.

Structure
REQ-031 SHALL place the state enumeration typedef and the STOP_BITS/DATA_W legal-range constants in shared package spart_pkg.
REQ-032 SHALL implement the FIFO as sub-module spart_tx_fifo (parameters DATA_W, FIFO_DEPTH; push/pop/full/empty/count).

Verification
REQ-033 SHALL cover single frame: DATA_W=8, write 8'h22, tick every 31 cycles -> txd sequence 0,0,1,0,0,0,1,0,0,1 per tick; busy low after stop.
REQ-034 SHALL cover back-to-back traffic: write 8'hA5 then 8'h3C -> second start bit follows first stop with zero idle bit periods; fifo_count 2->1->0.
REQ-035 SHALL cover overflow: FIFO_DEPTH=4, 5 writes with no ticks -> tbr=0 after 4th, overflow pulses once on 5th, only 4 frames transmitted.
REQ-036 SHALL cover parity: SPART_TX_PARITY_EN, parity_odd=0, data 8'h07 -> parity bit 1; parity_odd=1 -> parity bit 0.
REQ-037 SHALL cover reset mid-frame: rst asserted during DATA bit 3 -> txd=1, busy=0, fifo_count=0 the next cycle; no further frame without a new write.
REQ-038 SHALL cover STOP_BITS=2, DATA_W=5: write 5'h1F -> 1 start, 5 ones, 2 stop bit periods, then idle.
